mem_rsp_demux: RTL and testbench
================================

MEM_RSP_DEMUX -- requirements
Module: mem_rsp_demux

Interface
REQ-001 The block SHALL use parameter NPORTS, default 5, as the number of response consumers; the value comes from riscv_pkg.
REQ-002 The block SHALL use parameter TAG_DEPTH, default 4, as the number of outstanding-request tag FIFO entries, which must be a power of 2.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have the port req_valid, input, 1 bit: a request was issued; record its port tag.
REQ-006 The block SHALL have the port req_port, input, 3 bits: the index of the issuing consumer, 0..NPORTS-1.
REQ-007 The block SHALL have the port req_ready, output, 1 bit: a tag can be accepted.
REQ-008 The block SHALL have the port req_err, output, 1 bit: a 1-cycle pulse that flags an illegal req_port.
REQ-009 The block SHALL have the port rsp_valid, input, 1 bit: the memory response is valid.
REQ-010 The block SHALL have the port rsp_data, input, XLEN bits: the response data.
REQ-011 The block SHALL have the port rsp_ready, output, 1 bit: the response is accepted.
REQ-012 The block SHALL have the port out_valid, output, NPORTS bits: one-hot, the consumer that owns out_data.
REQ-013 The block SHALL have the port out_data, output, XLEN bits: the routed response data.
REQ-014 The block SHALL have the port out_ready, input, NPORTS bits: per-consumer accept.
REQ-015 The block SHALL have the port occupancy, output, 3 bits: the number of outstanding tags, 0..TAG_DEPTH.

Function
REQ-016 A tag SHALL be pushed when req_valid && req_ready && req_port<NPORTS.
REQ-017 req_ready SHALL equal !full, registered state only, with no combinational path from the pop side.
REQ-018 When req_valid && req_port>=NPORTS, the tag SHALL NOT be pushed, and req_err SHALL pulse high on the next cycle.
REQ-019 Responses SHALL be in order: each accepted response pops the oldest tag.
REQ-020 rsp_ready SHALL equal !empty && (stage==IDLE || stage drained this cycle).
REQ-021 A response with an empty FIFO SHALL stall (rsp_ready=0) and SHALL never be dropped or routed.
REQ-022 The output stage FSM SHALL have two states, IDLE and HOLD.
REQ-023 In IDLE, an accepted response SHALL register the data and tag, and the FSM SHALL move to HOLD.
REQ-024 In HOLD, out_valid SHALL be the one-hot of the held tag, and out_data SHALL be the held data.
REQ-025 HOLD SHALL be drained when out_ready[held tag]=1; out_ready bits of other ports SHALL be ignored.
REQ-026 After a drain with a new response accepted in the same cycle, the FSM SHALL stay in HOLD with the new data; after a drain with no new response, it SHALL go to IDLE.
REQ-027 Latency from rsp accept to out_valid SHALL be 1 cycle, and full throughput (1 response/cycle) SHALL be sustained when the consumer is always ready.
REQ-028 In IDLE, out_valid SHALL be 0 and out_data SHALL be 0.
REQ-029 Held data SHALL be stable while out_valid is asserted and not drained.
REQ-030 FIFO pointers SHALL be log2(TAG_DEPTH)+1 bits and wrap modulo 2*TAG_DEPTH; full is when the MSBs differ and the low bits are equal, and empty is when the pointers are equal.
REQ-031 A push and a pop in the same cycle SHALL leave occupancy unchanged; this is legal when neither full (push) nor empty (pop) blocks the operation.
REQ-032 A push while full SHALL be impossible because req_ready=0, and a req_valid while full SHALL have no effect.

Reset
REQ-033 rst SHALL be asynchronous assert, with release synchronised to clk.
REQ-034 While rst is high, the FIFO SHALL be empty, the FSM SHALL be in IDLE, occupancy=0, req_ready=0, req_err=0, rsp_ready=0, out_valid=0 and out_data=0.
REQ-035 A reset mid-operation SHALL discard all outstanding tags and the held response, with no out_valid glitch.
REQ-036 req_ready SHALL be 1 on the first clk edge after rst falls.

Structure
REQ-037 riscv_pkg SHALL hold XLEN, NPORTS=5, PORT_W=3, TAG_DEPTH=4 and the typedef for the output-stage FSM state (IDLE, HOLD).
REQ-038 The tag FIFO SHALL be one sub-module, tag_fifo, with push, pop, din, dout, full, empty and count; all other logic stays in mem_rsp_demux.

Verification
REQ-039 Reset: assert rst mid-HOLD with 3 tags outstanding -> out_valid=0, occupancy=0 immediately; req_ready=1 one cycle after release.
REQ-040 In-order routing: push tags 2,0,4; respond with 0xA, 0xB, 0xC with all out_ready=1 -> out_valid=00100/data 0xA, then 00001/0xB, then 10000/0xC, on consecutive cycles.
REQ-041 Backpressure: tag 3 with out_ready[3]=0 for 5 cycles and out_ready[1]=1 -> data held stable, rsp_ready=0 for the 2nd response, drain on the first cycle out_ready[3]=1.
REQ-042 Full/illegal tags: push 4 tags -> req_ready=0, occupancy=4; a 5th req_valid is ignored; req_port=6 -> req_err pulse and occupancy unchanged.
REQ-043 Empty stall and wrap: rsp_valid with no tags -> rsp_ready=0 indefinitely; then 10 push/pop pairs in the same cycle -> occupancy constant, correct ports across pointer wrap.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the memory response demultiplexer.
//   XLEN      : response data width
//   NPORTS    : number of response consumers
//   PORT_W    : width of a consumer index (tag)
//   TAG_DEPTH : outstanding-request tag FIFO entries (power of 2)
//   CNT_W     : width of the outstanding-tag count, 0..TAG_DEPTH
//   stage_e   : output-stage FSM state
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NPORTS    = 5;
    localparam int unsigned PORT_W    = 3;
    localparam int unsigned TAG_DEPTH = 4;
    localparam int unsigned CNT_W     = $clog2(TAG_DEPTH) + 1;

    typedef enum logic [0:0] {
        IDLE,
        HOLD
    } stage_e;

endpackage

// File: rtl/mem_rsp_demux_if.sv
// Handshake bundle between the request/response side and the consumers.
//   req_valid/req_port/req_ready/req_err : tag recording for issued requests
//   rsp_valid/rsp_data/rsp_ready         : in-order memory responses
//   out_valid/out_data/out_ready         : one-hot routed output to consumers
//   occupancy                            : number of outstanding tags
// Modports: slave = the demux, master = the side driving requests/responses.
interface mem_rsp_demux_if;
    import riscv_pkg::*;

    logic              req_valid;
    logic [PORT_W-1:0] req_port;
    logic              req_ready;
    logic              req_err;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_ready;
    logic [NPORTS-1:0] out_valid;
    logic [XLEN-1:0]   out_data;
    logic [NPORTS-1:0] out_ready;
    logic [CNT_W-1:0]  occupancy;

    modport slave (
        input  req_valid, req_port, rsp_valid, rsp_data, out_ready,
        output req_ready, req_err, rsp_ready, out_valid, out_data, occupancy
    );

    modport master (
        output req_valid, req_port, rsp_valid, rsp_data, out_ready,
        input  req_ready, req_err, rsp_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/tag_fifo.sv
// Outstanding-request tag FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write a tag (ignored when full)
//   pop/dout : remove the oldest tag (ignored when empty); dout shows the head
//   full, empty, count : status, count is 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign count = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wptr[AW-1:0]] <= din;
                wptr              <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_rsp_demux.sv
// Routes in-order memory responses back to the consumer that issued each request.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_rsp_demux_if.slave
//     req_*  : each legal request records its consumer index as a tag
//     rsp_*  : each accepted response pops the oldest tag
//     out_*  : one-cycle-latency registered output stage, one-hot out_valid
//     occupancy : outstanding tags
module mem_rsp_demux #(
    parameter int unsigned NPORTS    = riscv_pkg::NPORTS,
    parameter int unsigned TAG_DEPTH = riscv_pkg::TAG_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    mem_rsp_demux_if.slave   bus
);
    import riscv_pkg::*;

    logic              alive_q;
    logic              err_q;
    stage_e            state_q;
    logic [NPORTS-1:0] ov_q;
    logic [XLEN-1:0]   od_q;

    logic              port_ok;
    logic              push;
    logic              pop;
    logic              drain;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PORT_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;

    assign port_ok = (bus.req_port <= PORT_W'(NPORTS - 1));

    // alive_q holds ready low while in reset and releases it on the first edge after.
    assign bus.req_ready = alive_q && !fifo_full;
    assign push          = bus.req_valid && bus.req_ready && port_ok;

    // Only the owning consumer's ready bit can drain the held response.
    assign drain         = (state_q == HOLD) && |(ov_q & bus.out_ready);
    assign bus.rsp_ready = !fifo_empty && ((state_q == IDLE) || drain);
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    assign bus.req_err   = err_q;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.occupancy = fifo_count;

    tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (PORT_W)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.req_port),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            err_q   <= bus.req_valid && !port_ok;
        end
    end

    // Output stage: outputs are registered, so IDLE implies zero valid and data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ov_q    <= '0;
            od_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        ov_q    <= NPORTS'(1) << fifo_dout;
                        od_q    <= bus.rsp_data;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (drain) begin
                        if (pop) begin
                            ov_q <= NPORTS'(1) << fifo_dout;
                            od_q <= bus.rsp_data;
                        end else begin
                            ov_q    <= '0;
                            od_q    <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    ov_q    <= '0;
                    od_q    <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rsp_demux.sv
// Self-checking bench for mem_rsp_demux: directed scenarios plus random traffic,
// checked against a queue-based reference model and an output scoreboard.
module tb_mem_rsp_demux;
    import riscv_pkg::*;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [XLEN-1:0]   data;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_rsp_demux_if bus ();

    mem_rsp_demux dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    logic        chk_en = 1'b0;
    logic        err_exp = 1'b0;

    logic [PORT_W-1:0] tag_q [$];   // model: tags of requests awaiting a response
    item_t             out_q [$];   // scoreboard: responses awaiting delivery

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and hold for one cycle.
    task automatic drive(input logic rv, input logic [PORT_W-1:0] rp, input logic sv,
                         input logic [XLEN-1:0] sd, input logic [NPORTS-1:0] ordy);
        bus.req_valid = rv;
        bus.req_port  = rp;
        bus.rsp_valid = sv;
        bus.rsp_data  = sd;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: compares presented output with the oldest undelivered response.
    always @(posedge clk) begin
        #4;
        if (chk_en) begin
            if (out_q.size() == 0) begin
                chk("idle out_valid", 64'(bus.out_valid), 64'd0);
                chk("idle out_data", 64'(bus.out_data), 64'd0);
            end else begin
                item_t             e;
                logic [NPORTS-1:0] oh;
                e  = out_q[0];
                oh = '0;
                oh[e.port] = 1'b1;
                chk("out_valid", 64'(bus.out_valid), 64'(oh));
                chk("out_data", 64'(bus.out_data), 64'(e.data));
                if (bus.out_ready[e.port]) begin
                    void'(out_q.pop_front());
                end
            end
        end
    end

    // Reference model: tag bookkeeping and handshake expectations at mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_rsp_rdy;
            logic pushing;
            chk("req_ready", 64'(bus.req_ready), 64'(tag_q.size() < TAG_DEPTH));
            chk("occupancy", 64'(bus.occupancy), 64'(tag_q.size()));
            chk("req_err", 64'(bus.req_err), 64'(err_exp));
            // Output stage holds at most one response; empty queue means free or draining.
            exp_rsp_rdy = (tag_q.size() > 0) && (out_q.size() == 0);
            chk("rsp_ready", 64'(bus.rsp_ready), 64'(exp_rsp_rdy));
            err_exp = bus.req_valid && (bus.req_port >= PORT_W'(NPORTS));
            pushing = bus.req_valid && (bus.req_port < PORT_W'(NPORTS)) &&
                      (tag_q.size() < TAG_DEPTH);
            if (bus.rsp_valid && exp_rsp_rdy) begin
                item_t it;
                it.port = tag_q.pop_front();
                it.data = bus.rsp_data;
                out_q.push_back(it);
            end
            if (pushing) begin
                tag_q.push_back(bus.req_port);
            end
        end
    end

    localparam logic [NPORTS-1:0] ALL = '1;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_port  = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.out_ready = '0;

        // Reset state while rst is high.
        @(posedge clk);
        #1;
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst out_data", 64'(bus.out_data), 64'd0);
        chk("rst occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst rsp_ready", 64'(bus.rsp_ready), 64'd0);
        chk("rst req_err", 64'(bus.req_err), 64'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("req_ready after release", 64'(bus.req_ready), 64'd1);
        chk_en = 1'b1;

        // In-order routing: tags 2,0,4 then three back-to-back responses.
        drive(1'b1, 3'd2, 1'b0, 32'h0, ALL);
        drive(1'b1, 3'd0, 1'b0, 32'h0, ALL);
        drive(1'b1, 3'd4, 1'b0, 32'h0, ALL);
        drive(1'b0, 3'd0, 1'b1, 32'hA, ALL);
        chk("route0 valid", 64'(bus.out_valid), 64'b00100);
        chk("route0 data", 64'(bus.out_data), 64'hA);
        drive(1'b0, 3'd0, 1'b1, 32'hB, ALL);
        chk("route1 valid", 64'(bus.out_valid), 64'b00001);
        chk("route1 data", 64'(bus.out_data), 64'hB);
        drive(1'b0, 3'd0, 1'b1, 32'hC, ALL);
        chk("route2 valid", 64'(bus.out_valid), 64'b10000);
        chk("route2 data", 64'(bus.out_data), 64'hC);
        repeat (2) drive(1'b0, 3'd0, 1'b0, 32'h0, ALL);

        // Backpressure on port 3 while port 1 is ready.
        drive(1'b1, 3'd3, 1'b0, 32'h0, '0);
        drive(1'b1, 3'd1, 1'b0, 32'h0, '0);
        drive(1'b0, 3'd0, 1'b1, 32'h1111_0003, 5'b00010);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 3'd0, 1'b1, 32'h2222_0001, 5'b00010);
            chk("bp held data", 64'(bus.out_data), 64'h1111_0003);
            chk("bp rsp stalled", 64'(bus.rsp_ready), 64'd0);
        end
        drive(1'b0, 3'd0, 1'b1, 32'h2222_0001, 5'b01000);
        chk("bp next valid", 64'(bus.out_valid), 64'b00010);
        chk("bp next data", 64'(bus.out_data), 64'h2222_0001);
        repeat (2) drive(1'b0, 3'd0, 1'b0, 32'h0, ALL);

        // Full FIFO and illegal port.
        for (int i = 0; i < 4; i++) drive(1'b1, 3'(i), 1'b0, 32'h0, ALL);
        chk("full occupancy", 64'(bus.occupancy), 64'd4);
        chk("full req_ready", 64'(bus.req_ready), 64'd0);
        drive(1'b1, 3'd4, 1'b0, 32'h0, ALL);
        chk("5th ignored", 64'(bus.occupancy), 64'd4);
        drive(1'b1, 3'd6, 1'b0, 32'h0, ALL);
        chk("illegal err", 64'(bus.req_err), 64'd1);
        chk("illegal occupancy", 64'(bus.occupancy), 64'd4);
        drive(1'b0, 3'd0, 1'b0, 32'h0, ALL);
        chk("err one pulse", 64'(bus.req_err), 64'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 1'b1, $urandom, ALL);
        repeat (2) drive(1'b0, 3'd0, 1'b0, 32'h0, ALL);

        // Empty stall, then push/pop pairs across pointer wrap.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 3'd0, 1'b1, $urandom, ALL);
            chk("empty stall", 64'(bus.rsp_ready), 64'd0);
        end
        drive(1'b1, 3'($urandom_range(0, 4)), 1'b0, 32'h0, ALL);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'($urandom_range(0, 4)), 1'b1, $urandom, ALL);
            chk("pair occupancy", 64'(bus.occupancy), 64'd1);
        end
        drive(1'b0, 3'd0, 1'b1, $urandom, ALL);
        repeat (2) drive(1'b0, 3'd0, 1'b0, 32'h0, ALL);

        // Random traffic, then flush.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 3'($urandom_range(0, 6)), 1'($urandom), $urandom,
                  NPORTS'($urandom));
        end
        for (int i = 0; i < 10; i++) drive(1'b0, 3'd0, 1'b1, $urandom, ALL);
        repeat (2) drive(1'b0, 3'd0, 1'b0, 32'h0, ALL);

        // Reset in HOLD with 3 tags outstanding.
        for (int i = 0; i < 4; i++) drive(1'b1, 3'(i), 1'b0, 32'h0, '0);
        drive(1'b0, 3'd0, 1'b1, 32'hDEAD_BEEF, '0);
        chk("pre-reset occupancy", 64'(bus.occupancy), 64'd3);
        chk("pre-reset valid", 64'(bus.out_valid), 64'b00001);
        #1;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid rst out_data", 64'(bus.out_data), 64'd0);
        chk("mid rst occupancy", 64'(bus.occupancy), 64'd0);
        chk("mid rst req_ready", 64'(bus.req_ready), 64'd0);
        chk("mid rst rsp_ready", 64'(bus.rsp_ready), 64'd0);
        tag_q.delete();
        out_q.delete();
        err_exp = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post rst req_ready", 64'(bus.req_ready), 64'd1);
        chk("post rst occupancy", 64'(bus.occupancy), 64'd0);
        chk("post rst out_valid", 64'(bus.out_valid), 64'd0);
        chk_en = 1'b1;
        drive(1'b1, 3'd4, 1'b0, 32'h0, ALL);
        drive(1'b0, 3'd0, 1'b1, 32'h1234_5678, ALL);
        repeat (3) drive(1'b0, 3'd0, 1'b0, 32'h0, ALL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
